// File: rtl/mul4_pkg.sv
// Shared definitions for the 4x4 shift-add multiplier: controller states,
// shift encodings and the control-word decode used by the sequencer.
package mul4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH2 = 2'b01;
  localparam logic [1:0] SH4 = 2'b10;

  localparam int         NUM_STEPS = 4;
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       ld_a;
    logic       ld_b;
    logic       rst_out;
    logic       ld_out;
    logic       l_1;
    logic       l_2;
    logic [1:0] shctrl;
  } ctrl_t;

  // Moore decode: the control word is a pure function of state and step.
  // Partial products go lo*lo, hi*lo, lo*hi, hi*hi with shifts 0, 2, 2, 4.
  function automatic ctrl_t decode(state_t s, logic [1:0] step);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: c.ready = 1'b1;
      INIT: begin
        c.busy    = 1'b1;
        c.ld_a    = 1'b1;
        c.ld_b    = 1'b1;
        c.rst_out = 1'b1;
      end
      STEP: begin
        c.busy   = 1'b1;
        c.ld_out = 1'b1;
        case (step)
          2'd0: c.shctrl = SH0;
          2'd1: begin
            c.l_1    = 1'b1;
            c.shctrl = SH2;
          end
          2'd2: begin
            c.l_2    = 1'b1;
            c.shctrl = SH2;
          end
          default: begin
            c.l_1    = 1'b1;
            c.l_2    = 1'b1;
            c.shctrl = SH4;
          end
        endcase
      end
      DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul4_sequencer_if.sv
// Requester handshake plus every datapath control pin of the multiplier
// sequencer; master is the sequencer side, slave the requester/datapath side.
interface mul4_sequencer_if;
  logic start;
  logic ready;
  logic busy;
  logic done;
  logic ld_A;
  logic ld_B;
  logic rst_out;
  logic l_1;
  logic l_2;
  logic shctrl_1;
  logic shctrl_0;
  logic ld_out;

  modport master (
    input  start,
    output ready, busy, done, ld_A, ld_B, rst_out,
           l_1, l_2, shctrl_1, shctrl_0, ld_out
  );

  modport slave (
    output start,
    input  ready, busy, done, ld_A, ld_B, rst_out,
           l_1, l_2, shctrl_1, shctrl_0, ld_out
  );
endinterface

// File: rtl/mul4_sequencer.sv
// Sequencing controller for the 4x4 shift-add multiplier: load operands,
// clear the accumulator, accumulate four shifted 2x2 products, pulse done.
module mul4_sequencer
  import mul4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mul4_sequencer_if.master bus
);

  state_t     state, state_nxt;
  logic [1:0] step,  step_nxt;
  ctrl_t      ctrl;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: if (bus.start) state_nxt = INIT;
      INIT: begin
        state_nxt = STEP;
        step_nxt  = 2'd0;
      end
      STEP: begin
        step_nxt = step + 2'd1;
        if (step == LAST_STEP) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the decode of the next state, so they line
  // up with the state register without any combinational path from start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= 2'd0;
      ctrl  <= decode(IDLE, 2'd0);
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      ctrl  <= decode(state_nxt, step_nxt);
    end
  end

  assign bus.ready    = ctrl.ready;
  assign bus.busy     = ctrl.busy;
  assign bus.done     = ctrl.done;
  assign bus.ld_A     = ctrl.ld_a;
  assign bus.ld_B     = ctrl.ld_b;
  assign bus.rst_out  = ctrl.rst_out;
  assign bus.ld_out   = ctrl.ld_out;
  assign bus.l_1      = ctrl.l_1;
  assign bus.l_2      = ctrl.l_2;
  assign bus.shctrl_1 = ctrl.shctrl[1];
  assign bus.shctrl_0 = ctrl.shctrl[0];

endmodule

// File: tb/tb_mul4_sequencer.sv
// Bench for mul4_sequencer: a behavioural shift-add datapath driven by the
// controller, a cycle timeline model, and directed multiply vectors.
module tb_mul4_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mul4_sequencer_if bus ();

  mul4_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural datapath: operand registers, 2x2 multiply, shift, accumulate.
  logic [3:0] a_reg, b_reg;
  logic [7:0] acc;

  function automatic logic [7:0] dp_term(logic [3:0] a, logic [3:0] b,
                                         logic s1, logic s2, logic [1:0] sh);
    int x, y, p;
    x = s1 ? int'(a[3:2]) : int'(a[1:0]);
    y = s2 ? int'(b[3:2]) : int'(b[1:0]);
    p = x * y;
    case (sh)
      2'b00:   return 8'(p);
      2'b01:   return 8'(p * 4);
      2'b10:   return 8'(p * 16);
      default: return 8'hxx;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.ld_A) a_reg <= a_in;
    if (bus.ld_B) b_reg <= b_in;
    if (bus.rst_out) acc <= 8'd0;
    else if (bus.ld_out)
      acc <= acc + dp_term(a_reg, b_reg, bus.l_1, bus.l_2, {bus.shctrl_1, bus.shctrl_0});
  end

  // Reference: sum of the first k partial products in the order
  // lo*lo, hi*lo<<2, lo*hi<<2, hi*hi<<4.
  function automatic int partial(int a, int b, int k);
    int t[4];
    int s;
    t[0] = (a % 4) * (b % 4);
    t[1] = (a / 4) * (b % 4) * 4;
    t[2] = (a % 4) * (b / 4) * 4;
    t[3] = (a / 4) * (b / 4) * 16;
    s = 0;
    for (int i = 0; i < k; i++) s += t[i];
    return s;
  endfunction

  // Timeline model: phase 0 idle, 1 init, 2..5 steps, 6 done.
  int mph = 0;
  int ma = 0, mb = 0;

  always @(posedge clk) begin
    if (rst) mph <= 0;
    else if (mph == 0) mph <= bus.start ? 1 : 0;
    else if (mph == 6) mph <= 0;
    else mph <= mph + 1;
    if (!rst && mph == 1) begin
      ma <= int'(a_in);
      mb <= int'(b_in);
    end
  end

  // {ready,busy,done,ld_A,ld_B,rst_out,ld_out,l_1,l_2,shctrl_1,shctrl_0}
  function automatic int exp_vec(int ph);
    case (ph)
      0:       return 11'b100_0000_0000;
      1:       return 11'b010_1110_0000;
      2:       return 11'b010_0001_0000;
      3:       return 11'b010_0001_1001;
      4:       return 11'b010_0001_0101;
      5:       return 11'b010_0001_1110;
      default: return 11'b001_0000_0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl_vec",
            int'({bus.ready, bus.busy, bus.done, bus.ld_A, bus.ld_B, bus.rst_out,
                  bus.ld_out, bus.l_1, bus.l_2, bus.shctrl_1, bus.shctrl_0}),
            exp_vec(mph));
      if (mph >= 2) check("acc_model", int'(acc), partial(ma, mb, mph - 2));
    end
  end

  logic [7:0] acc_hist [1:6];
  logic       done_hist[1:6];

  // Pulse start in idle at a negedge, then record six cycles after accept.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    a_in      = a;
    b_in      = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      acc_hist[i]  = acc;
      done_hist[i] = bus.done;
    end
  endtask

  task automatic checkOutput(input string name, input int product);
    for (int i = 1; i <= 5; i++) check({name, "_early_done"}, int'(done_hist[i]), 0);
    check({name, "_done"}, int'(done_hist[6]), 1);
    check({name, "_product"}, int'(acc_hist[6]), product);
  endtask

  int dcnt;
  int dcyc[$];

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", int'(bus.ready), 1);
      check("idle_done", int'(bus.done), 0);
    end

    // 0xB * 0x7 with per-step accumulator values.
    applyStimulus(4'hB, 4'h7);
    check("b7_acc_s0", int'(acc_hist[3]), 9);
    check("b7_acc_s1", int'(acc_hist[4]), 33);
    check("b7_acc_s2", int'(acc_hist[5]), 45);
    checkOutput("b7", 8'h4D);

    // Largest product, then back-to-back at the first ready cycle.
    @(negedge clk);
    applyStimulus(4'hF, 4'hF);
    checkOutput("ff", 225);
    @(negedge clk);
    check("ff_ready_after", int'(bus.ready), 1);
    applyStimulus(4'h6, 4'h3);
    checkOutput("63", 8'h12);

    // Start held high: one multiply every 7 cycles.
    @(negedge clk);
    a_in = 4'h2;
    b_in = 4'h5;
    bus.start = 1'b1;
    dcnt = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        dcyc.push_back(i);
        check("held_product", int'(acc), 8'h0A);
      end
    end
    bus.start = 1'b0;
    check("held_count", dcnt, 3);
    if (dcyc.size() == 3) begin
      check("held_first", dcyc[0], 6);
      check("held_gap1", dcyc[1] - dcyc[0], 7);
      check("held_gap2", dcyc[2] - dcyc[1], 7);
    end
    @(negedge clk);

    // Reset during step 2 aborts without done.
    a_in = 4'h9;
    b_in = 4'h9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", int'(bus.ready), 1);
    check("abort_busy", int'(bus.busy), 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    applyStimulus(4'h3, 4'h3);
    checkOutput("33", 8'h09);

    // Reset and start on the same edge: request dropped.
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rs_ready", int'(bus.ready), 1);
    check("rs_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("rs_no_init", int'(bus.ld_A), 0);
    check("rs_still_ready", int'(bus.ready), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
